// File: rtl/sync_debounce.sv
// Debouncer for a raw asynchronous single-bit input: two-flop synchroniser,
// stability-qualifying FSM, registered level/edge outputs and a saturating glitch counter.
module sync_debounce #(
    parameter int STABLE_CYCLES = 8,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                dout_q, dout_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                busy_q, busy_d;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser stage: only sync2_q is ever seen by the state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HI: begin
                // The level is judged on the qualifying sample itself.
                if (!sync2_q) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = sat_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = sat_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        dout_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        busy_d = (state_d == WAIT_HI)   || (state_d == WAIT_LO);
    end

    // Qualification stage: state, counters and all outputs are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            glitch_q <= '0;
            dout_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce (STABLE_CYCLES = 8): reset, clean rise, bounce
// rejection, 7/8-sample boundary, glitch counter saturation and reset mid-WAIT.
module tb_sync_debounce;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       dout;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;

    logic any_fall, any_rise, any_low, any_busy;

    sync_debounce #(
        .STABLE_CYCLES(8),
        .GLITCH_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .dout      (dout),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (fall) any_fall = 1'b1;
        if (rise) any_rise = 1'b1;
        if (!dout) any_low = 1'b1;
        if (busy) any_busy = 1'b1;
    endtask

    task automatic clr_flags();
        any_fall = 1'b0;
        any_rise = 1'b0;
        any_low  = 1'b0;
        any_busy = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        din   = 1'b1;
        clr_flags();
        #3 rst_n = 1'b0;

        // Reset held with din high: everything stays clear.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_outputs", {dout, rise, fall, busy, glitch_cnt}, 32'h0);
        end
        din = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_after_reset", {dout, busy, glitch_cnt}, 32'h0);

        // Clean rise: din high before posedge N, dout rises at N+9.
        din = 1'b1;
        clr_flags();
        step();
        chk("rise_busy_N", busy, 1'b0);
        step();
        chk("rise_busy_N1", busy, 1'b0);
        step();
        chk("rise_busy_N2", busy, 1'b1);
        repeat (6) step();
        chk("rise_N8_pending", {dout, rise, busy}, 3'b001);
        step();
        chk("rise_N9_dout_rise", {dout, rise, busy}, 3'b110);
        chk("rise_N9_glitch", glitch_cnt, 8'd0);
        step();
        chk("rise_N10_single_pulse", {dout, rise}, 2'b10);

        // Bounce rejection: three 3-cycle low pulses separated by 2 high cycles.
        clr_flags();
        for (int b = 0; b < 3; b++) begin
            din = 1'b0;
            repeat (3) step();
            din = 1'b1;
            repeat (2) step();
        end
        repeat (10) step();
        chk("bounce_no_fall", any_fall, 1'b0);
        chk("bounce_dout_held", any_low, 1'b0);
        chk("bounce_busy_seen", any_busy, 1'b1);
        chk("bounce_glitch_cnt", glitch_cnt, 8'd3);

        // Boundary: 7 low samples abort.
        clr_flags();
        din = 1'b0;
        repeat (7) step();
        din = 1'b1;
        repeat (12) step();
        chk("low7_no_fall", {any_fall, any_low}, 2'b00);
        chk("low7_glitch_cnt", glitch_cnt, 8'd4);

        // Boundary: 8 low samples qualify, fall at N+9.
        clr_flags();
        din = 1'b0;
        repeat (9) step();
        chk("low8_N8_pending", {dout, fall, any_fall}, 3'b100);
        step();
        chk("low8_N9_fall", {dout, fall}, 2'b01);
        step();
        chk("low8_N10_single_pulse", {dout, fall}, 2'b00);
        chk("low8_glitch_unchanged", glitch_cnt, 8'd4);

        // Saturation: single-cycle high glitches from the low state.
        clr_flags();
        for (int g = 0; g < 100; g++) begin
            din = 1'b1;
            step();
            din = 1'b0;
            step();
        end
        repeat (4) step();
        chk("sat_partial_cnt", glitch_cnt, 8'd104);
        for (int g = 0; g < 200; g++) begin
            din = 1'b1;
            step();
            din = 1'b0;
            step();
        end
        repeat (4) step();
        chk("sat_full_cnt", glitch_cnt, 8'd255);
        for (int g = 0; g < 5; g++) begin
            din = 1'b1;
            step();
            din = 1'b0;
            step();
        end
        repeat (4) step();
        chk("sat_holds", glitch_cnt, 8'd255);
        chk("sat_no_edges", {any_rise, any_fall, dout}, 3'b000);

        // Reset in the middle of a WAIT_LO qualification.
        din = 1'b1;
        repeat (12) step();
        chk("mid_pre_high", dout, 1'b1);
        din = 1'b0;
        repeat (4) step();
        chk("mid_waiting", {dout, busy}, 2'b11);
        clr_flags();
        #5 rst_n = 1'b0;
        #1;
        chk("mid_async_clear", {dout, busy, rise, fall, glitch_cnt}, 32'h0);
        din = 1'b1;
        step();
        step();
        chk("mid_in_reset", {dout, any_fall, glitch_cnt}, 32'h0);
        rst_n = 1'b1;
        clr_flags();
        repeat (2) step();
        chk("mid_release_N1", busy, 1'b0);
        step();
        chk("mid_release_N2_busy", busy, 1'b1);
        repeat (6) step();
        chk("mid_release_N8_no_rise", {any_rise, dout, any_fall}, 3'b000);
        step();
        chk("mid_release_N9_rise", {dout, rise}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
